// File: rtl/mdma_ecc_pkg.sv
// Shared SECDED definitions for the MDMA buffer RAM: check-bit sizing, H-matrix
// columns (Hamming positions of data bits) and the per-lane error classification.
package mdma_ecc_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    SBE  = 2'd1,
    DBE  = 2'd2
  } lane_err_t;

  // Hamming position of one codeword bit; also the syndrome word before trimming.
  typedef logic [15:0] syn_word_t;

  // Hamming check bits plus one overall-parity bit (8 for a 64-bit lane).
  function automatic int unsigned ecc_w(input int unsigned lane_w);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 16; i++) begin
      if ((32'd1 << r) < lane_w + r + 1) r++;
    end
    return r + 1;
  endfunction

  // H-matrix column of data bit j: the j-th non-power-of-two position (3,5,6,7,9,...).
  function automatic syn_word_t data_pos(input int unsigned j);
    syn_word_t p;
    p = syn_word_t'(j + 3);
    for (int i = 2; i < 16; i++) begin
      if (p >= syn_word_t'(32'd1 << i)) p = p + 16'd1;
    end
    return p;
  endfunction

endpackage

// File: rtl/mdma_secded_lane.sv
// Combinational SECDED encoder and decoder for one lane. Codeword layout is
// {ecc, data}; ecc[ECC_W-1] is the overall parity over data and Hamming bits.
module mdma_secded_lane import mdma_ecc_pkg::*; #(
  parameter int LANE_W = 64,
  parameter int ECC_W  = 8
) (
  input  logic [LANE_W-1:0] enc_dat,
  output logic [ECC_W-1:0]  enc_ecc,
  input  logic [LANE_W-1:0] dec_dat,
  input  logic [ECC_W-1:0]  dec_ecc,
  output logic [LANE_W-1:0] dec_fix,
  output lane_err_t         dec_err
);

  localparam int R = ECC_W - 1;

  logic [R-1:0] col [LANE_W];
  logic [R-1:0] enc_chk;
  logic [R-1:0] dec_chk;
  logic [R-1:0] syn;
  logic         par;

  for (genvar j = 0; j < LANE_W; j++) begin : g_col
    localparam syn_word_t P = data_pos(j);
    assign col[j] = P[R-1:0];
  end

  always_comb begin
    enc_chk = '0;
    dec_chk = '0;
    for (int j = 0; j < LANE_W; j++) begin
      if (enc_dat[j]) enc_chk = enc_chk ^ col[j];
      if (dec_dat[j]) dec_chk = dec_chk ^ col[j];
    end
  end

  assign enc_ecc = {^{enc_dat, enc_chk}, enc_chk};
  assign syn     = dec_chk ^ dec_ecc[R-1:0];
  assign par     = ^{dec_dat, dec_ecc};

  // Odd overall parity means one flipped bit; a zero syndrome then points at the parity bit itself.
  always_comb begin
    dec_fix = dec_dat;
    dec_err = NONE;
    if (par) begin
      dec_err = SBE;
      for (int j = 0; j < LANE_W; j++) begin
        if (col[j] == syn) dec_fix[j] = ~dec_dat[j];
      end
    end else if (syn != '0) begin
      dec_err = DBE;
    end
  end

endmodule

// File: rtl/mdma_ecc_ram_ctl.sv
// Simple-dual-port MDMA buffer RAM with per-lane SECDED, write->read forwarding,
// RD_LAT 1/2 read pipeline, saturating error counters and first-error capture.
module mdma_ecc_ram_ctl import mdma_ecc_pkg::*; #(
  parameter  int DATA_W = 512,
  parameter  int LANE_W = 64,
  parameter  int DEPTH  = 32,
  parameter  int RD_LAT = 1,
  parameter  int CNT_W  = 16,
  localparam int ADR_W  = $clog2(DEPTH),
  localparam int NL     = DATA_W / LANE_W,
  localparam int ECC_W  = ecc_w(LANE_W),
  localparam int CW     = LANE_W + ECC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wen,
  input  logic [ADR_W-1:0]  wadr,
  input  logic [NL-1:0]     wben,
  input  logic [DATA_W-1:0] wdat,
  input  logic              ren,
  input  logic [ADR_W-1:0]  radr,
  output logic              rvld,
  output logic [DATA_W-1:0] rdat,
  output logic              rsbe,
  output logic              rdbe,
  input  logic              inj_sbe,
  input  logic              inj_dbe,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  sbe_cnt,
  output logic [CNT_W-1:0]  dbe_cnt,
  output logic              err_adr_vld,
  output logic [ADR_W-1:0]  err_adr
);

  // Handshake: ren/radr are accepted every cycle (no back-pressure); rvld is a
  // one-cycle pulse RD_LAT cycles later and rdat/rsbe/rdbe are meaningful only with it.
  logic              wadr_ok, radr_ok;
  logic [1:0]        inj;
  logic              v1, oor1;
  logic [ADR_W-1:0]  adr1;
  logic [NL-1:0]     byp1;
  logic [DATA_W-1:0] bdat1;
  logic [DATA_W-1:0] lane_dat;
  logic [NL-1:0]     lane_sbe, lane_dbe;
  logic [DATA_W-1:0] d_dat;
  logic              d_sbe, d_dbe;
  logic              fin_vld, fin_sbe, fin_dbe, fin_err;
  logic [DATA_W-1:0] fin_dat;
  logic [ADR_W-1:0]  fin_adr;

  assign wadr_ok = int'(wadr) < DEPTH;
  assign radr_ok = int'(radr) < DEPTH;
  assign inj     = inj_dbe ? 2'b11 : {1'b0, inj_sbe};

  for (genvar l = 0; l < NL; l++) begin : g_lane
    logic [CW-1:0]     mem [DEPTH];
    logic [CW-1:0]     rcw1;
    logic [CW-1:0]     wcw;
    logic [ECC_W-1:0]  wecc;
    logic [LANE_W-1:0] fix;
    lane_err_t         err;

    mdma_secded_lane #(.LANE_W(LANE_W), .ECC_W(ECC_W)) u_secded (
      .enc_dat (wdat[l*LANE_W +: LANE_W]),
      .enc_ecc (wecc),
      .dec_dat (rcw1[LANE_W-1:0]),
      .dec_ecc (rcw1[CW-1:LANE_W]),
      .dec_fix (fix),
      .dec_err (err)
    );

    assign wcw = {wecc, wdat[l*LANE_W +: LANE_W]} ^ ((l == 0) ? CW'(inj) : '0);

    always_ff @(posedge clk) begin
      if (wen && wben[l] && wadr_ok) mem[wadr] <= wcw;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   rcw1 <= '0;
      else if (ren) rcw1 <= radr_ok ? mem[radr] : '0;
    end

    // Forwarded lanes carry fresh write data, so they never report errors.
    assign lane_dat[l*LANE_W +: LANE_W] = byp1[l] ? bdat1[l*LANE_W +: LANE_W] : fix;
    assign lane_sbe[l] = !byp1[l] && (err == SBE);
    assign lane_dbe[l] = !byp1[l] && (err == DBE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      oor1  <= 1'b0;
      adr1  <= '0;
      byp1  <= '0;
      bdat1 <= '0;
    end else begin
      v1 <= ren;
      if (ren) begin
        oor1  <= !radr_ok;
        adr1  <= radr;
        byp1  <= (wen && wadr_ok && (radr == wadr)) ? wben : '0;
        bdat1 <= wdat;
      end
    end
  end

  assign d_dat = oor1 ? '0 : lane_dat;
  assign d_sbe = v1 && !oor1 && (|lane_sbe);
  assign d_dbe = v1 && !oor1 && (|lane_dbe);

  if (RD_LAT == 2) begin : g_lat2
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        fin_vld <= 1'b0;
        fin_sbe <= 1'b0;
        fin_dbe <= 1'b0;
        fin_dat <= '0;
        fin_adr <= '0;
      end else begin
        fin_vld <= v1;
        fin_sbe <= d_sbe;
        fin_dbe <= d_dbe;
        fin_dat <= d_dat;
        fin_adr <= adr1;
      end
    end
  end else begin : g_lat1
    assign fin_vld = v1;
    assign fin_sbe = d_sbe;
    assign fin_dbe = d_dbe;
    assign fin_dat = d_dat;
    assign fin_adr = adr1;
  end

  assign fin_err = fin_sbe | fin_dbe;

  // err_clr restarts from the beat in the same cycle rather than discarding it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbe_cnt     <= '0;
      dbe_cnt     <= '0;
      err_adr_vld <= 1'b0;
      err_adr     <= '0;
    end else if (err_clr) begin
      sbe_cnt     <= CNT_W'(fin_sbe);
      dbe_cnt     <= CNT_W'(fin_dbe);
      err_adr_vld <= fin_err;
      err_adr     <= fin_err ? fin_adr : '0;
    end else begin
      if (fin_sbe && (sbe_cnt != '1)) sbe_cnt <= sbe_cnt + CNT_W'(1);
      if (fin_dbe && (dbe_cnt != '1)) dbe_cnt <= dbe_cnt + CNT_W'(1);
      if (fin_err && !err_adr_vld) begin
        err_adr_vld <= 1'b1;
        err_adr     <= fin_adr;
      end
    end
  end

  assign rvld = fin_vld;
  assign rdat = fin_dat;
  assign rsbe = fin_sbe;
  assign rdbe = fin_dbe;

endmodule

// File: tb/tb_mdma_ecc_ram_ctl.sv
// Directed bench: two controllers share one stimulus stream, one built with
// RD_LAT=1/CNT_W=4 and one with RD_LAT=2/CNT_W=16, each checked at its own latency.
module tb_mdma_ecc_ram_ctl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wen, ren, inj_sbe, inj_dbe, err_clr;
  logic [4:0]   wadr, radr;
  logic [7:0]   wben;
  logic [511:0] wdat;

  logic         rvld1, rsbe1, rdbe1, vld1;
  logic [511:0] rdat1;
  logic [3:0]   sbe_cnt1, dbe_cnt1;
  logic [4:0]   err_adr1;
  logic         rvld2, rsbe2, rdbe2, vld2;
  logic [511:0] rdat2;
  logic [15:0]  sbe_cnt2, dbe_cnt2;
  logic [4:0]   err_adr2;

  int n_chk  = 0;
  int n_fail = 0;

  logic [511:0] pat_a, pat_b, pat_c, pat_d, pat_e, exp_m;

  always #5 clk = ~clk;

  mdma_ecc_ram_ctl #(.RD_LAT(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .wen(wen), .wadr(wadr), .wben(wben), .wdat(wdat),
    .ren(ren), .radr(radr), .rvld(rvld1), .rdat(rdat1), .rsbe(rsbe1), .rdbe(rdbe1),
    .inj_sbe(inj_sbe), .inj_dbe(inj_dbe), .err_clr(err_clr),
    .sbe_cnt(sbe_cnt1), .dbe_cnt(dbe_cnt1), .err_adr_vld(vld1), .err_adr(err_adr1)
  );

  mdma_ecc_ram_ctl #(.RD_LAT(2), .CNT_W(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .wen(wen), .wadr(wadr), .wben(wben), .wdat(wdat),
    .ren(ren), .radr(radr), .rvld(rvld2), .rdat(rdat2), .rsbe(rsbe2), .rdbe(rdbe2),
    .inj_sbe(inj_sbe), .inj_dbe(inj_dbe), .err_clr(err_clr),
    .sbe_cnt(sbe_cnt2), .dbe_cnt(dbe_cnt2), .err_adr_vld(vld2), .err_adr(err_adr2)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_b1(input string tag, input logic [511:0] d, input logic s, input logic e);
    chk({tag, "/d1.rvld"}, rvld1, 1'b1);
    chk({tag, "/d1.rdat"}, rdat1, d);
    chk({tag, "/d1.rsbe"}, rsbe1, s);
    chk({tag, "/d1.rdbe"}, rdbe1, e);
  endtask

  task automatic chk_b2(input string tag, input logic [511:0] d, input logic s, input logic e);
    chk({tag, "/d2.rvld"}, rvld2, 1'b1);
    chk({tag, "/d2.rdat"}, rdat2, d);
    chk({tag, "/d2.rsbe"}, rsbe2, s);
    chk({tag, "/d2.rdbe"}, rdbe2, e);
  endtask

  task automatic chk_err(input string tag, input logic [15:0] s1, input logic [15:0] s2,
                         input logic [15:0] dd, input logic v, input logic [4:0] a);
    chk({tag, "/d1.sbe_cnt"}, sbe_cnt1, s1);
    chk({tag, "/d2.sbe_cnt"}, sbe_cnt2, s2);
    chk({tag, "/d1.dbe_cnt"}, dbe_cnt1, dd);
    chk({tag, "/d2.dbe_cnt"}, dbe_cnt2, dd);
    chk({tag, "/d1.err_adr_vld"}, vld1, v);
    chk({tag, "/d2.err_adr_vld"}, vld2, v);
    chk({tag, "/d1.err_adr"}, err_adr1, a);
    chk({tag, "/d2.err_adr"}, err_adr2, a);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] be, input logic [511:0] d,
                          input logic s, input logic e);
    wen = 1'b1; wadr = a; wben = be; wdat = d; inj_sbe = s; inj_dbe = e;
    @(posedge clk); #1;
    wen = 1'b0; inj_sbe = 1'b0; inj_dbe = 1'b0;
  endtask

  // Any write set up by the caller lands in the same cycle as the read.
  task automatic do_read(input string tag, input logic [4:0] a, input logic [511:0] d,
                         input logic s, input logic e);
    ren = 1'b1; radr = a;
    @(posedge clk); #1;
    ren = 1'b0; wen = 1'b0; inj_sbe = 1'b0; inj_dbe = 1'b0;
    chk_b1(tag, d, s, e);
    @(posedge clk); #1;
    chk_b2(tag, d, s, e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pat_a = {8{64'hDEAD_BEEF_0123_4567}};
    pat_b = {8{64'h0BAD_F00D_CAFE_0001}};
    pat_c = {8{64'hC0DE_C0DE_5555_AAAA}};
    pat_d = {8{64'h1357_9BDF_2468_ACE0}};
    pat_e = {8{64'hFFFF_0000_A5A5_5A5A}};
    rst_n = 1'b0; wen = 1'b0; wadr = '0; wben = '0; wdat = '0;
    ren = 1'b0; radr = '0; inj_sbe = 1'b0; inj_dbe = 1'b0; err_clr = 1'b0;

    // Reset state
    idle(3);
    chk("rst/d1.rvld", rvld1, 1'b0);
    chk("rst/d2.rvld", rvld2, 1'b0);
    chk("rst/d1.rdat", rdat1, '0);
    chk("rst/d2.rdat", rdat2, '0);
    chk("rst/d1.flags", {rsbe1, rdbe1}, 2'b00);
    chk("rst/d2.flags", {rsbe2, rdbe2}, 2'b00);
    chk_err("rst", 16'd0, 16'd0, 16'd0, 1'b0, 5'd0);
    rst_n = 1'b1;
    idle(1);

    // Clean write then read
    do_write(5'd3, 8'hFF, pat_a, 1'b0, 1'b0);
    do_read("t1", 5'd3, pat_a, 1'b0, 1'b0);

    // Injected single-bit error is corrected and counted
    do_write(5'd5, 8'hFF, pat_d, 1'b1, 1'b0);
    do_read("t2", 5'd5, pat_d, 1'b1, 1'b0);
    idle(1);
    chk_err("t2", 16'd1, 16'd1, 16'd0, 1'b1, 5'd5);

    // Injected double-bit error, two back-to-back reads; data returned raw
    do_write(5'd6, 8'hFF, pat_e, 1'b0, 1'b1);
    exp_m = pat_e ^ 512'h3;
    ren = 1'b1; radr = 5'd6;
    @(posedge clk); #1;
    chk_b1("t3a", exp_m, 1'b0, 1'b1);
    @(posedge clk); #1;
    ren = 1'b0;
    chk_b1("t3b", exp_m, 1'b0, 1'b1);
    chk_b2("t3a", exp_m, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk_b2("t3b", exp_m, 1'b0, 1'b1);
    idle(1);
    chk_err("t3", 16'd1, 16'd1, 16'd2, 1'b1, 5'd5);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk_err("t3clr", 16'd0, 16'd0, 16'd0, 1'b0, 5'd0);

    // Same-cycle write/read collision with partial lanes
    do_write(5'd7, 8'hFF, pat_b, 1'b0, 1'b0);
    exp_m = {pat_b[511:256], pat_c[255:0]};
    wen = 1'b1; wadr = 5'd7; wben = 8'h0F; wdat = pat_c;
    do_read("t4col", 5'd7, exp_m, 1'b0, 1'b0);
    do_write(5'd7, 8'h00, pat_a, 1'b0, 1'b0);
    do_read("t4nop", 5'd7, exp_m, 1'b0, 1'b0);

    // Counter saturation on the 4-bit build, 16-bit build keeps counting
    do_write(5'd9, 8'hFF, pat_d, 1'b1, 1'b0);
    ren = 1'b1; radr = 5'd9;
    repeat (16) @(posedge clk);
    #1 ren = 1'b0;
    idle(3);
    chk_err("t5sat", 16'h000F, 16'd16, 16'd0, 1'b1, 5'd9);
    ren = 1'b1;
    repeat (3) @(posedge clk);
    #1 ren = 1'b0;
    idle(3);
    chk_err("t5hold", 16'h000F, 16'd19, 16'd0, 1'b1, 5'd9);
    do_write(5'd11, 8'hFF, pat_a, 1'b1, 1'b0);
    ren = 1'b1; radr = 5'd11;
    @(posedge clk); #1;
    ren = 1'b0; err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    idle(2);
    chk_err("t5clr", 16'd1, 16'd1, 16'd0, 1'b1, 5'd11);

    // Reset before the lat-1 beat: nothing emerges from either build
    ren = 1'b1; radr = 5'd3;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    ren = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("t6a/d1.rvld", rvld1, 1'b0);
      chk("t6a/d2.rvld", rvld2, 1'b0);
    end
    chk_err("t6a", 16'd0, 16'd0, 16'd0, 1'b0, 5'd0);

    // Reset while the lat-2 read is still in its pipeline
    ren = 1'b1; radr = 5'd3;
    @(posedge clk); #1;
    ren = 1'b0;
    chk_b1("t6b", pat_a, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("t6b/d2.rvld", rvld2, 1'b0);
    end
    do_read("t6post", 5'd3, pat_a, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
